// File: rtl/sub_nibble_serial.sv
// Serial W-bit subtractor: drives an external 4-bit full subtractor one nibble
// per clock, rippling the borrow through a register between nibbles.
module sub_nibble_serial #(
  parameter int NIB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NIB-1:0]  opa,
  input  logic [4*NIB-1:0]  opb,
  input  logic              bin_in,
  output logic [3:0]        sub_a,
  output logic [3:0]        sub_b,
  output logic              sub_bin,
  input  logic [3:0]        sub_diff,
  input  logic              sub_bout,
  output logic [4*NIB-1:0]  result,
  output logic              bout_out,
  output logic              ovf,
  output logic              zero,
  output logic              busy,
  output logic              done
);

  localparam int W  = 4 * NIB;
  localparam int IW = $clog2(NIB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            borrow;
  logic [W-1:0]    opa_reg;
  logic [W-1:0]    opb_reg;
  logic [W-1:0]    res_next;
  logic [IW+1:0]   base;
  logic            last;

  assign base = {idx, 2'b00};
  assign last = (idx == IW'(NIB - 1));

  always_comb begin
    sub_a   = '0;
    sub_b   = '0;
    sub_bin = 1'b0;
    if (state == RUN) begin
      sub_a   = opa_reg[base +: 4];
      sub_b   = opb_reg[base +: 4];
      sub_bin = borrow;
    end
  end

  // Result with the current nibble merged in, so flags on the final edge see it
  always_comb begin
    res_next = (result & ~(W'(4'hF) << base)) | (W'(sub_diff) << base);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      borrow   <= 1'b0;
      opa_reg  <= '0;
      opb_reg  <= '0;
      result   <= '0;
      bout_out <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa_reg <= opa;
            opb_reg <= opb;
            borrow  <= bin_in;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          result <= res_next;
          borrow <= sub_bout;
          idx    <= idx + 1'b1;
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bout_out <= sub_bout;
            ovf      <= (opa_reg[W-1] != opb_reg[W-1]) && (res_next[W-1] != opa_reg[W-1]);
            zero     <= (res_next == '0);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
